// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU encodings. Covers decoder command codes, access
//                size codes, the sign-select bit and load/store unit states.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Command codes from the control decoder (only loads and stores reach memory)
    typedef enum logic [1:0] {
        OTHER   = 2'b00,
        JMP_CMD = 2'b01,
        ST_CMD  = 2'b10,
        LW_CMD  = 2'b11
    } cmd_e;

    // Access size field, sx_cntl[1:0]
    typedef enum logic [1:0] {
        FULL   = 2'b00,
        HALF   = 2'b01,
        BYTE   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    // Extension select, sx_cntl[2]
    localparam logic SIGN   = 1'b1;
    localparam logic UNSIGN = 1'b0;

    // Load/store unit states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/cpu_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_lsu_align
//  Description : Combinational lane logic for the load/store unit. Produces
//                store byte enables and replicated store data, and extracts
//                and extends load data from the returned memory word.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_lsu_align
    import cpu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_sign,
    input  logic [31:0] ld_rdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    output logic [31:0] ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: byte enables and lane-replicated write data
    always_comb begin
        st_be        = 4'b0000;
        st_wdata_rep = st_wdata;
        case (size_e'(st_size))
            FULL: begin
                st_be        = 4'b1111;
                st_wdata_rep = st_wdata;
            end
            HALF: begin
                st_be        = st_lane[1] ? 4'b1100 : 4'b0011;
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            BYTE: begin
                st_be        = 4'b0001 << st_lane;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            default: begin
                st_be        = 4'b0000;
                st_wdata_rep = st_wdata;
            end
        endcase
    end

    // Load side: select the addressed lane, then sign- or zero-extend it
    always_comb begin
        w_half = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_lane)
            2'd0:    w_byte = ld_rdata[7:0];
            2'd1:    w_byte = ld_rdata[15:8];
            2'd2:    w_byte = ld_rdata[23:16];
            default: w_byte = ld_rdata[31:24];
        endcase
        case (size_e'(ld_size))
            HALF:    ld_data = {{16{ld_sign & w_half[15]}}, w_half};
            BYTE:    ld_data = {{24{ld_sign & w_byte[7]}}, w_byte};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_lsu
//  Description : Load/store unit. Accepts decoded load/store ops, runs one
//                req/ack transaction to data memory, returns extended load
//                data, stalls upstream while busy and flags misalignment or
//                a memory timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_lsu
    import cpu_pkg::*;
#(
    parameter int AW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lsu_valid,
    input  logic [1:0]    cmd,
    input  logic [2:0]    sx_cntl,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          kill,
    output logic          stall,
    output logic          rd_valid,
    output logic [31:0]   rd_data,
    output logic          err_misalign,
    output logic          err_timeout,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ack,
    input  logic [31:0]   dmem_rdata
);

    // A zero timeout disables the abort; keep the counter at least one bit wide
    localparam int            CW         = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit            c_to_en    = (TIMEOUT_CYC != 0);
    localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT_CYC - 1);

    lsu_state_e    r_state;
    lsu_state_e    w_next;

    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic          r_sign;
    logic [1:0]    r_size;
    logic [1:0]    r_lane;
    logic          r_killed;
    logic          r_err_to;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rdata;

    logic          w_is_mem;
    logic          w_accept;
    logic          w_misalign;
    logic          w_to_hit;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_rep;
    logic [31:0]   w_ld_ext;

    assign w_is_mem   = (cmd_e'(cmd) == LW_CMD) || (cmd_e'(cmd) == ST_CMD);
    assign w_accept   = (r_state == ST_IDLE) && lsu_valid && w_is_mem && !kill;
    assign w_misalign = (size_e'(sx_cntl[1:0]) == SZ_ILL)
                     || ((size_e'(sx_cntl[1:0]) == HALF) && addr[0])
                     || ((size_e'(sx_cntl[1:0]) == FULL) && (addr[1:0] != 2'b00));
    assign w_to_hit   = c_to_en && (r_cnt == c_cnt_last);

    // Store lanes come from the incoming op; load extract uses the held op
    cpu_lsu_align u_align (
        .st_size      (sx_cntl[1:0]),
        .st_lane      (addr[1:0]),
        .st_wdata     (wdata),
        .ld_size      (r_size),
        .ld_lane      (r_lane),
        .ld_sign      (r_sign),
        .ld_rdata     (dmem_rdata),
        .st_be        (w_be),
        .st_wdata_rep (w_wdata_rep),
        .ld_data      (w_ld_ext)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an ack wins over a same-cycle timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_misalign ? ST_ERR : ST_REQ;
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    w_next = ST_DONE;
                end else if (w_to_hit) begin
                    w_next = ST_ERR;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Transaction registers, kill flag, timeout counter and load capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_be     <= 4'b0000;
            r_wdata  <= 32'd0;
            r_sign   <= UNSIGN;
            r_size   <= 2'b00;
            r_lane   <= 2'b00;
            r_killed <= 1'b0;
            r_err_to <= 1'b0;
            r_cnt    <= '0;
            r_rdata  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_killed <= 1'b0;
                r_err_to <= 1'b0;
                r_cnt    <= '0;
                if (!w_misalign) begin
                    r_we    <= (cmd_e'(cmd) == ST_CMD);
                    r_addr  <= {addr[AW-1:2], 2'b00};
                    r_be    <= w_be;
                    r_wdata <= w_wdata_rep;
                    r_sign  <= sx_cntl[2];
                    r_size  <= sx_cntl[1:0];
                    r_lane  <= addr[1:0];
                end
            end else if (r_state == ST_REQ) begin
                if (kill) begin
                    r_killed <= 1'b1;
                end
                if (dmem_ack) begin
                    r_rdata <= w_ld_ext;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_to_hit) begin
                        r_err_to <= 1'b1;
                    end
                end
            end
        end
    end

    // Bus and pipeline outputs; req derives from state so reset drops it at once
    always_comb begin
        dmem_req     = (r_state == ST_REQ);
        dmem_we      = r_we;
        dmem_addr    = r_addr;
        dmem_be      = r_be;
        dmem_wdata   = r_wdata;
        stall        = w_accept || (r_state == ST_REQ);
        rd_valid     = (r_state == ST_DONE) && !r_we && !r_killed && !kill;
        rd_data      = r_rdata;
        err_misalign = (r_state == ST_ERR) && !r_err_to;
        err_timeout  = (r_state == ST_ERR) && r_err_to;
    end

endmodule
`default_nettype wire
